// File: rtl/tone_generator.sv
// Square-wave tone generator: turns a half-period code (in 1 us ticks) into a
// 50 % duty speaker drive. Rate and stop requests take effect only at period boundaries.
module tone_generator #(
  parameter int TICK_DIV = 50,
  parameter int RATE_W   = 13,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RATE_W-1:0] slow_rate,
  input  logic              enable,
  output logic              speaker,
  output logic              tone_active,
  output logic              period_done,
  output logic [CNT_W-1:0]  period_count
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t            state;
  logic [PRE_W-1:0]  prescaler;
  logic [RATE_W-1:0] hp_cnt;
  logic [RATE_W-1:0] active_rate;
  logic              start;
  logic              tick;
  logic              half_end;

  assign start    = enable && (slow_rate != '0);
  assign tick     = (state != IDLE) && (prescaler == PRE_W'(TICK_DIV - 1));
  // active_rate is never 0 outside IDLE, so the subtraction cannot wrap here
  assign half_end = tick && (hp_cnt == active_rate - RATE_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      speaker      <= 1'b0;
      tone_active  <= 1'b0;
      period_done  <= 1'b0;
      period_count <= '0;
      prescaler    <= '0;
      hp_cnt       <= '0;
      active_rate  <= '0;
    end else begin
      period_done <= 1'b0;

      // Prescaler is parked at 0 in IDLE and free-runs across HIGH/LOW
      if (state == IDLE) begin
        prescaler <= '0;
        hp_cnt    <= '0;
      end else begin
        prescaler <= tick ? '0 : prescaler + PRE_W'(1);
        if (half_end)  hp_cnt <= '0;
        else if (tick) hp_cnt <= hp_cnt + RATE_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            active_rate  <= slow_rate;
            period_count <= '0;
            state        <= HIGH;
            speaker      <= 1'b1;
            tone_active  <= 1'b1;
          end
        end
        HIGH: begin
          if (half_end) begin
            state   <= LOW;
            speaker <= 1'b0;
          end
        end
        LOW: begin
          if (half_end) begin
            period_done <= 1'b1;
            if (period_count != '1) period_count <= period_count + CNT_W'(1);
            if (start) begin
              active_rate <= slow_rate;
              state       <= HIGH;
              speaker     <= 1'b1;
            end else begin
              state       <= IDLE;
              tone_active <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          speaker     <= 1'b0;
          tone_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: directed scenarios plus random enable/rate traffic,
// compared every cycle against a phase-countdown reference model.
module tb_tone_generator;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] slow_rate;
  logic        enable;
  logic        speaker, tone_active, period_done;
  logic [15:0] period_count;
  logic        speaker2, tone_active2, period_done2;
  logic [1:0]  period_count2;

  int checks = 0;
  int failures = 0;

  // Reference model: a phase is just "rate*TD cycles remaining"
  int m_phase;   // 0 idle, 1 high, 2 low
  int m_remain;
  int m_rate;
  int m_cnt;
  bit m_done;

  tone_generator #(.TICK_DIV(TD), .RATE_W(13), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .slow_rate(slow_rate), .enable(enable),
    .speaker(speaker), .tone_active(tone_active), .period_done(period_done),
    .period_count(period_count));

  tone_generator #(.TICK_DIV(TD), .RATE_W(13), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .slow_rate(slow_rate), .enable(enable),
    .speaker(speaker2), .tone_active(tone_active2), .period_done(period_done2),
    .period_count(period_count2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_remain = 0; m_rate = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit st;
    st = enable && (slow_rate != 0);
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (st) begin
             m_rate = int'(slow_rate); m_remain = m_rate * TD; m_phase = 1; m_cnt = 0;
           end
        1: begin
             m_remain--;
             if (m_remain == 0) begin m_phase = 2; m_remain = m_rate * TD; end
           end
        default: begin
             m_remain--;
             if (m_remain == 0) begin
               m_done = 1;
               if (m_cnt < 65535) m_cnt++;
               if (st) begin
                 m_rate = int'(slow_rate); m_remain = m_rate * TD; m_phase = 1;
               end else begin
                 m_phase = 0;
               end
             end
           end
      endcase
    end
  endtask

  task automatic check_all();
    chk("speaker", int'(speaker), int'(m_phase == 1));
    chk("tone_active", int'(tone_active), int'(m_phase != 0));
    chk("period_done", int'(period_done), int'(m_done));
    chk("period_count", int'(period_count), m_cnt);
    chk("speaker_w2", int'(speaker2), int'(m_phase == 1));
    chk("period_count_w2", int'(period_count2), (m_cnt > 3) ? 3 : m_cnt);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    bit   seen;
    prev = speaker;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle();
      if (!prev && speaker) seen = 1;
      prev = speaker;
    end
    chk({tag, "_rise_timeout"}, int'(seen), 1);
  endtask

  initial begin
    int saved;
    rst_n = 1'b0; enable = 1'b0; slow_rate = '0;
    model_reset();
    #23;
    chk("rst_speaker", int'(speaker), 0);
    chk("rst_active", int'(tone_active), 0);
    chk("rst_count", int'(period_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // Basic tone, five periods (also saturates the 2-bit counter)
    enable = 1'b1; slow_rate = 13'd3;
    run(73);
    chk("basic_count3", int'(period_count), 3);
    chk("basic_done", int'(period_done), 1);
    run(48);
    chk("basic_count5", int'(period_count), 5);
    chk("sat_count_w2", int'(period_count2), 3);

    // Rate change at cycle 4 of a HIGH phase
    wait_rise("rate");
    run(3);
    slow_rate = 13'd5;
    run(90);

    // Stop mid-high
    slow_rate = 13'd3;
    wait_rise("stop");
    run(1);
    enable = 1'b0;
    saved = m_cnt;
    run(40);
    chk("stop_idle", int'(tone_active), 0);
    chk("stop_count", int'(period_count), saved + 1);

    // Zero rate from IDLE
    enable = 1'b1; slow_rate = '0;
    run(20);
    chk("zero_idle", int'(tone_active), 0);

    // Zero rate mid-play, restored before the LOW end
    slow_rate = 13'd3;
    wait_rise("zr");
    run(5);
    slow_rate = '0;
    run(15);
    slow_rate = 13'd3;
    run(40);

    // Async reset between edges during HIGH
    wait_rise("arst");
    run(3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_speaker", int'(speaker), 0);
    chk("arst_active", int'(tone_active), 0);
    chk("arst_count", int'(period_count), 0);
    run(2);
    rst_n = 1'b1;
    run(30);

    // Minimum rate
    slow_rate = 13'd1;
    run(40);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) enable = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) slow_rate = 13'($urandom_range(6));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Consumes the 13-bit half-period code from the key-to-frequency stage and drives the speaker pin with a 50 % duty square wave.
- slow_rate is the half-period in microsecond ticks (1909 → 262 Hz).
- Rate and stop requests are applied only at full-period boundaries, so the waveform is glitch-free and every high phase runs its full length.
- Sits between the key-to-frequency stage and the board speaker/buzzer pin.

Parameters:
- TICK_DIV, 50, clk cycles per 1 µs tick (50 MHz clk); the bench overrides it with 4.
- RATE_W, 13, width of slow_rate / active_rate.
- CNT_W, 16, width of the saturating completed-period counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- slow_rate  in  RATE_W  requested half-period in µs ticks; 0 = silence.
- enable  in  1  play request; 0 = stop at the next period boundary.
- speaker  out  1  square-wave output, registered.
- tone_active  out  1  high whenever state != IDLE.
- period_done  out  1  one-cycle pulse at the end of each completed period.
- period_count  out  CNT_W  completed periods since the last start, saturating at all-ones.

Behaviour:
- Reset (async, rst_n=0), effective immediately including mid-tone:
  - state=IDLE, speaker=0, tone_active=0, period_done=0, period_count=0.
  - prescaler=0, hp_cnt=0, active_rate=0.
- States: IDLE, HIGH, LOW. speaker is a register that equals 1 exactly when state is HIGH.
- start = enable && slow_rate != 0, sampled on a clk edge.
- IDLE:
  - prescaler and hp_cnt are held at 0.
  - On an edge where start=1: active_rate<=slow_rate, period_count<=0, state<=HIGH.
  - speaker is high from the cycle after start is sampled; latency is 1 clk.
- Tick prescaler, when not IDLE:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for the single cycle where prescaler==TICK_DIV-1.
  - The prescaler restarts at 0 on every IDLE→HIGH entry and is free-running across HIGH/LOW transitions.
- Half-period counter:
  - On each tick, hp_cnt increments.
  - half_end = tick && hp_cnt==active_rate-1. On half_end, hp_cnt<=0.
  - Each phase lasts exactly active_rate*TICK_DIV clk cycles.
- HIGH: on half_end → LOW. No rate reload and no stop check here; a high phase is never truncated.
- LOW: on half_end:
  - period_done pulses 1 cycle, registered on the same edge as the transition.
  - period_count increments, saturating at 2^CNT_W-1.
  - If start=1: active_rate<=slow_rate, state<=HIGH.
  - Else: state<=IDLE and speaker stays 0.
- Rate changes mid-period are ignored until the LOW→HIGH boundary. Both halves of a period always use the same active_rate.
- enable dropping, or slow_rate going to 0, mid-period lets the current period finish before the block goes IDLE.
- enable re-asserted before the boundary continues the tone seamlessly, with no extra IDLE cycle.
- slow_rate=1 is legal: each phase is TICK_DIV cycles. Max value 8191 needs no overflow guard; hp_cnt is RATE_W bits wide.
- Simultaneous events: a start condition on the same edge as LOW half_end is evaluated with that edge's inputs. Reset dominates everything.
- period_count holds its value in IDLE until the next start.

Test Plan (all TICK_DIV=4):
1. Basic tone:
   - Stimulus: rst_n released, enable=1, slow_rate=3.
   - Response: speaker rises 1 cycle later, then repeats 12 cycles high / 12 cycles low. period_done pulses every 24 cycles; period_count reads 1, 2, 3.
2. Rate change mid-high:
   - Stimulus: slow_rate=3 playing, slow_rate changed to 5 at cycle 4 of a HIGH phase.
   - Response: the current HIGH and LOW stay at 12 cycles each; the next HIGH is 20 cycles.
3. Stop mid-high:
   - Stimulus: enable=0 at cycle 2 of a HIGH phase with slow_rate=3.
   - Response: HIGH completes its 12 cycles and LOW completes its 12 cycles. period_done pulses once, then IDLE: tone_active=0, speaker=0, period_count held.
4. Zero rate and re-enable:
   - Stimulus (a): slow_rate=0 with enable=1 from IDLE. Response: speaker stays 0 and tone_active stays 0.
   - Stimulus (b): slow_rate=0 during PLAY, then enable/slow_rate restored before the LOW end. Response: no IDLE gap; the next HIGH starts on the boundary.
5. Async reset mid-tone:
   - Stimulus: rst_n pulled low between clock edges during HIGH.
   - Response: speaker=0, tone_active=0, period_count=0 immediately. After release with start=1, the first HIGH is the full 12 cycles.
6. Edge values:
   - Stimulus (a): slow_rate=1. Response: 4 high / 4 low.
   - Stimulus (b): CNT_W overridden to 2 and 5 periods run. Response: period_count saturates at 3.
